// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Owns the byte-wide external RAM port. Arbitrates between instruction
//   fetch (fixed 4-byte reads) and the load/store buffer (1/2/4-byte reads
//   and writes). Each request is serialised into little-endian byte
//   accesses. The assembled data is returned together with a one-cycle
//   done pulse.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   rdy_in          global ready; low freezes every register
//   rob_clear_up    pipeline flush; aborts reads, lets writes finish
//   io_buffer_full  UART buffer full; holds off IO-space stores
//   mem_din         RAM read byte, valid one cycle after its address
//   mem_dout        RAM write byte
//   mem_a           RAM byte address
//   mem_wr          1 = write, 0 = read
//   if_valid        fetch request, held until if_done
//   if_addr         fetch address
//   if_done         one-cycle pulse, if_data valid
//   if_data         fetched word
//   lsb_valid       LSB request, held until lsb_done
//   lsb_wr          1 = store, 0 = load
//   lsb_size        0 = 1 byte, 1 = 2 bytes, anything else = 4 bytes
//   lsb_addr        access address
//   lsb_wdata       store data, low N bytes used
//   lsb_done        one-cycle pulse, load data valid / store retired
//   lsb_rdata       load data, zero-extended
module mem_arbiter #(
    parameter logic [31:0] IO_ADDR_MASK = 32'h0003_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_clear_up,
    input  logic        io_buffer_full,

    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,

    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,

    input  logic        lsb_valid,
    input  logic        lsb_wr,
    input  logic [2:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSB = 1'b1;

    logic [1:0]  state;
    logic        owner;
    logic [31:0] base;
    logic [2:0]  len;
    // Edge counter since acceptance: the accept edge is 0, the next edge 1.
    logic [2:0]  cnt;
    logic [31:0] acc;
    logic [31:0] wbuf;

    logic        lsb_is_io;
    logic        lsb_ok;
    logic        if_ok;
    logic [2:0]  lsb_len;
    logic [31:0] issue_addr;
    logic [1:0]  cap_idx;
    logic [31:0] acc_next;
    logic [7:0]  wr_byte;

    // Acceptance qualifiers. A requester still holds valid during the cycle
    // its done pulse is high, so that cycle must not start a second access.
    always_comb begin
        lsb_is_io = (lsb_addr & IO_ADDR_MASK) == IO_ADDR_MASK;
        lsb_ok    = lsb_valid && !lsb_done && !(lsb_wr && lsb_is_io && io_buffer_full);
        if_ok     = if_valid && !if_done;
    end

    always_comb begin
        case (lsb_size)
            3'd0:    lsb_len = 3'd1;
            3'd1:    lsb_len = 3'd2;
            default: lsb_len = 3'd4;
        endcase
    end

    // Byte k is addressed on edge k (wrap-around add).
    assign issue_addr = base + {29'd0, cnt};

    // The RAM answers one cycle after the address is registered, so the byte
    // sampled on edge k belongs to the address issued on edge k-2.
    assign cap_idx = 2'(cnt - 3'd2);

    always_comb begin
        acc_next = acc;
        case (cap_idx)
            2'd0: acc_next[7:0]   = mem_din;
            2'd1: acc_next[15:8]  = mem_din;
            2'd2: acc_next[23:16] = mem_din;
            2'd3: acc_next[31:24] = mem_din;
            default: acc_next = acc;
        endcase
    end

    always_comb begin
        case (cnt[1:0])
            2'd0: wr_byte = wbuf[7:0];
            2'd1: wr_byte = wbuf[15:8];
            2'd2: wr_byte = wbuf[23:16];
            2'd3: wr_byte = wbuf[31:24];
            default: wr_byte = '0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            owner     <= OWNER_IF;
            base      <= '0;
            len       <= '0;
            cnt       <= '0;
            acc       <= '0;
            wbuf      <= '0;
            mem_a     <= '0;
            mem_dout  <= '0;
            mem_wr    <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
        end else if (rdy_in) begin
            // Done pulses and their data are only present for one cycle.
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;

            case (state)
                IDLE: begin
                    if (!rob_clear_up) begin
                        if (lsb_ok) begin
                            owner <= OWNER_LSB;
                            base  <= lsb_addr;
                            len   <= lsb_len;
                            cnt   <= 3'd1;
                            acc   <= '0;
                            wbuf  <= lsb_wdata;
                            mem_a <= lsb_addr;
                            if (lsb_wr) begin
                                mem_wr   <= 1'b1;
                                mem_dout <= lsb_wdata[7:0];
                                state    <= WRITE;
                            end else begin
                                mem_wr   <= 1'b0;
                                mem_dout <= '0;
                                state    <= READ;
                            end
                        end else if (if_ok) begin
                            owner    <= OWNER_IF;
                            base     <= if_addr;
                            len      <= 3'd4;
                            cnt      <= 3'd1;
                            acc      <= '0;
                            mem_a    <= if_addr;
                            mem_wr   <= 1'b0;
                            mem_dout <= '0;
                            state    <= READ;
                        end
                    end
                end

                READ: begin
                    if (rob_clear_up) begin
                        // Partial data is simply abandoned; acc is cleared
                        // again on the next acceptance.
                        state <= IDLE;
                        mem_a <= '0;
                    end else begin
                        if (cnt < len) begin
                            mem_a <= issue_addr;
                        end
                        if (cnt >= 3'd2) begin
                            acc <= acc_next;
                        end
                        if (cnt == len + 3'd1) begin
                            state <= IDLE;
                            mem_a <= '0;
                            if (owner == OWNER_LSB) begin
                                lsb_done  <= 1'b1;
                                lsb_rdata <= acc_next;
                            end else begin
                                if_done <= 1'b1;
                                if_data <= acc_next;
                            end
                        end
                        cnt <= cnt + 3'd1;
                    end
                end

                WRITE: begin
                    // Flushes do not affect stores: they are already committed.
                    if (cnt == len) begin
                        mem_wr   <= 1'b0;
                        mem_dout <= '0;
                        mem_a    <= '0;
                        lsb_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        mem_a    <= issue_addr;
                        mem_dout <= wr_byte;
                        cnt      <= cnt + 3'd1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    mem_a  <= '0;
                    mem_wr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. A byte RAM model (64 KiB, indexed by
//   the low 16 address bits) answers reads one cycle after the address and
//   logs every write. The RAM shares the global ready, so it is frozen
//   together with the arbiter while rdy_in is low.
module tb_mem_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear_up;
    logic        io_buffer_full;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_valid;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_valid;
    logic        lsb_wr;
    logic [2:0]  lsb_size;
    logic [31:0] lsb_addr;
    logic [31:0] lsb_wdata;
    logic        lsb_done;
    logic [31:0] lsb_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0]  ram [0:65535];
    logic [31:0] wlog_a [$];
    logic [7:0]  wlog_d [$];
    logic [31:0] trace [0:31];

    mem_arbiter #(.IO_ADDR_MASK(32'h0003_0000)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .rob_clear_up(rob_clear_up),
        .io_buffer_full(io_buffer_full),
        .mem_din(mem_din),
        .mem_dout(mem_dout),
        .mem_a(mem_a),
        .mem_wr(mem_wr),
        .if_valid(if_valid),
        .if_addr(if_addr),
        .if_done(if_done),
        .if_data(if_data),
        .lsb_valid(lsb_valid),
        .lsb_wr(lsb_wr),
        .lsb_size(lsb_size),
        .lsb_addr(lsb_addr),
        .lsb_wdata(lsb_wdata),
        .lsb_done(lsb_done),
        .lsb_rdata(lsb_rdata)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (rdy_in) begin
            if (mem_wr) begin
                ram[mem_a[15:0]] = mem_dout;
                wlog_a.push_back(mem_a);
                wlog_d.push_back(mem_dout);
            end
            mem_din <= ram[mem_a[15:0]];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        step();
        step();
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h required 0", mem_a); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b required 0", mem_wr); end
        checks++; if (mem_dout !== 8'h0) begin errors++; $display("FAIL reset_mem_dout: got %h required 0", mem_dout); end
        checks++; if ({if_done, lsb_done} !== 2'b00) begin errors++; $display("FAIL reset_done: got %b required 00", {if_done, lsb_done}); end
        checks++; if ({if_data, lsb_rdata} !== 64'h0) begin errors++; $display("FAIL reset_data: got %h required 0", {if_data, lsb_rdata}); end
        rst_in = 1'b0;
        step();
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL idle_mem_a: got %h required 0", mem_a); end
    endtask

    task automatic test_fetch();
        int n = 0;
        logic saw_wr = 1'b0;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h00; ram[16'h0103] = 8'h00;
        if_addr  = 32'h100;
        if_valid = 1'b1;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            step();
            trace[i] = mem_a;
            if (mem_wr) saw_wr = 1'b1;
            if (if_done) n = i;
        end
        if_valid = 1'b0;
        // n counts edges from the accept edge inclusive: done after E5 -> 6.
        checks++; if (n !== 6) begin errors++; $display("FAIL fetch_latency: got edge %0d required 6", n); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (trace[k+1] !== 32'h100 + k) begin errors++; $display("FAIL fetch_addr%0d: got %h required %h", k, trace[k+1], 32'h100 + k); end
        end
        checks++; if (if_data !== 32'h00000513) begin errors++; $display("FAIL fetch_data: got %h required 00000513", if_data); end
        checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL fetch_no_write: got %b required 0", saw_wr); end
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL fetch_mem_a_idle: got %h required 0", mem_a); end
        step();
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse: got %b required 0", if_done); end
        checks++; if (if_data !== 32'h0) begin errors++; $display("FAIL fetch_data_idle: got %h required 0", if_data); end
    endtask

    task automatic test_arbitration();
        int n = 0;
        logic if_seen = 1'b0;
        ram[16'h0200] = 8'hF0;
        ram[16'h0300] = 8'h37; ram[16'h0301] = 8'h01; ram[16'h0302] = 8'h00; ram[16'h0303] = 8'h00;
        if_addr   = 32'h300;
        if_valid  = 1'b1;
        lsb_addr  = 32'h200;
        lsb_wr    = 1'b0;
        lsb_size  = 3'd0;
        lsb_valid = 1'b1;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step();
            trace[i] = mem_a;
            if (if_done) if_seen = 1'b1;
            if (lsb_done) n = i;
        end
        lsb_valid = 1'b0;
        checks++; if (trace[1] !== 32'h200) begin errors++; $display("FAIL arb_lsb_first: got %h required 00000200", trace[1]); end
        checks++; if (n !== 3) begin errors++; $display("FAIL arb_lsb_latency: got edge %0d required 3", n); end
        checks++; if (lsb_rdata !== 32'h000000F0) begin errors++; $display("FAIL arb_lsb_rdata: got %h required 000000f0", lsb_rdata); end
        checks++; if (if_seen !== 1'b0) begin errors++; $display("FAIL arb_if_early: got %b required 0", if_seen); end
        step();
        checks++; if (mem_a !== 32'h300) begin errors++; $display("FAIL arb_if_accept: got %h required 00000300", mem_a); end
        n = 0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step();
            if (if_done) n = i;
        end
        if_valid = 1'b0;
        checks++; if (n !== 5) begin errors++; $display("FAIL arb_if_latency: got edge %0d required 5", n); end
        checks++; if (if_data !== 32'h00000137) begin errors++; $display("FAIL arb_if_data: got %h required 00000137", if_data); end
        step();
    endtask

    task automatic test_halfword_store();
        int n = 0;
        int wr_cnt = 0;
        wlog_a.delete();
        wlog_d.delete();
        lsb_addr  = 32'h1FFF;
        lsb_wdata = 32'hAABBCCDD;
        lsb_size  = 3'd1;
        lsb_wr    = 1'b1;
        lsb_valid = 1'b1;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step();
            if (mem_wr) wr_cnt++;
            if (lsb_done) n = i;
        end
        lsb_valid = 1'b0;
        checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL hw_wr_cycles: got %0d required 2", wr_cnt); end
        checks++; if (n !== 3) begin errors++; $display("FAIL hw_done_latency: got edge %0d required 3", n); end
        checks++; if (wlog_a.size() !== 2) begin errors++; $display("FAIL hw_write_count: got %0d required 2", wlog_a.size()); end
        checks++; if (wlog_a[0] !== 32'h1FFF || wlog_d[0] !== 8'hDD) begin errors++; $display("FAIL hw_byte0: got %h@%h required dd@00001fff", wlog_d[0], wlog_a[0]); end
        checks++; if (wlog_a[1] !== 32'h2000 || wlog_d[1] !== 8'hCC) begin errors++; $display("FAIL hw_byte1: got %h@%h required cc@00002000", wlog_d[1], wlog_a[1]); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL hw_wr_low: got %b required 0", mem_wr); end
        step();
    endtask

    task automatic test_io_stall();
        int n = 0;
        int if_cnt = 0;
        logic [31:0] if_val = '0;
        logic saw_wr = 1'b0;
        logic lsb_early = 1'b0;
        wlog_a.delete();
        wlog_d.delete();
        io_buffer_full = 1'b1;
        lsb_addr  = 32'h0003_0000;
        lsb_wdata = 32'h0000005A;
        lsb_size  = 3'd0;
        lsb_wr    = 1'b1;
        lsb_valid = 1'b1;
        if_addr   = 32'h100;
        if_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (mem_wr) saw_wr = 1'b1;
            if (lsb_done) lsb_early = 1'b1;
            if (if_done) begin
                if_cnt++;
                if_val   = if_data;
                if_valid = 1'b0;
            end
        end
        checks++; if (saw_wr !== 1'b0) begin errors++; $display("FAIL io_stall_no_write: got %b required 0", saw_wr); end
        checks++; if (lsb_early !== 1'b0) begin errors++; $display("FAIL io_stall_no_done: got %b required 0", lsb_early); end
        checks++; if (if_cnt !== 1) begin errors++; $display("FAIL io_fetch_count: got %0d required 1", if_cnt); end
        checks++; if (if_val !== 32'h00000513) begin errors++; $display("FAIL io_fetch_data: got %h required 00000513", if_val); end
        io_buffer_full = 1'b0;
        for (int i = 1; i <= 10 && n == 0; i++) begin
            step();
            if (lsb_done) n = i;
        end
        lsb_valid = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL io_write_latency: got edge %0d required 2", n); end
        checks++; if (wlog_a.size() !== 1) begin errors++; $display("FAIL io_write_count: got %0d required 1", wlog_a.size()); end
        checks++; if (wlog_a[0] !== 32'h0003_0000 || wlog_d[0] !== 8'h5A) begin errors++; $display("FAIL io_write_byte: got %h@%h required 5a@00030000", wlog_d[0], wlog_a[0]); end
        step();
    endtask

    task automatic test_flush();
        int n = 0;
        logic if_seen = 1'b0;
        logic [31:0] exp_w = 32'h11223344;
        if_addr  = 32'h100;
        if_valid = 1'b1;
        step();
        step();
        step();
        rob_clear_up = 1'b1;
        step();
        checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL flush_mem_a: got %h required 0", mem_a); end
        rob_clear_up = 1'b0;
        if_valid     = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (if_done) if_seen = 1'b1;
        end
        checks++; if (if_seen !== 1'b0) begin errors++; $display("FAIL flush_no_done: got %b required 0", if_seen); end

        ram[16'h0400] = 8'h93; ram[16'h0401] = 8'h00; ram[16'h0402] = 8'h10; ram[16'h0403] = 8'h00;
        if_addr  = 32'h400;
        if_valid = 1'b1;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            step();
            if (if_done) n = i;
        end
        if_valid = 1'b0;
        checks++; if (n !== 6) begin errors++; $display("FAIL flush_refetch_latency: got edge %0d required 6", n); end
        checks++; if (if_data !== 32'h00100093) begin errors++; $display("FAIL flush_refetch_data: got %h required 00100093", if_data); end
        step();

        wlog_a.delete();
        wlog_d.delete();
        n = 0;
        lsb_addr  = 32'h500;
        lsb_wdata = exp_w;
        lsb_size  = 3'd2;
        lsb_wr    = 1'b1;
        lsb_valid = 1'b1;
        for (int i = 1; i <= 12 && n == 0; i++) begin
            step();
            rob_clear_up = (i == 2);
            if (lsb_done) n = i;
        end
        rob_clear_up = 1'b0;
        lsb_valid    = 1'b0;
        checks++; if (n !== 5) begin errors++; $display("FAIL flush_store_done: got edge %0d required 5", n); end
        checks++; if (wlog_a.size() !== 4) begin errors++; $display("FAIL flush_store_count: got %0d required 4", wlog_a.size()); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (wlog_a[k] !== 32'h500 + k || wlog_d[k] !== exp_w[8*k +: 8]) begin
                errors++;
                $display("FAIL flush_store_byte%0d: got %h@%h required %h@%h", k, wlog_d[k], wlog_a[k], exp_w[8*k +: 8], 32'h500 + k);
            end
        end
        step();
    endtask

    task automatic test_rdy_and_reset();
        int n = 0;
        logic bad = 1'b0;
        if_addr  = 32'h400;
        if_valid = 1'b1;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            step();
            trace[i] = mem_a;
            if (i == 2) rdy_in = 1'b0;
            if (i == 5) rdy_in = 1'b1;
            if (if_done) n = i;
        end
        rdy_in   = 1'b1;
        if_valid = 1'b0;
        checks++; if (n !== 9) begin errors++; $display("FAIL rdy_latency: got edge %0d required 9", n); end
        checks++; if (if_data !== 32'h00100093) begin errors++; $display("FAIL rdy_data: got %h required 00100093", if_data); end
        checks++; if (trace[5] !== 32'h401) begin errors++; $display("FAIL rdy_frozen_addr: got %h required 00000401", trace[5]); end
        checks++; if (trace[6] !== 32'h402) begin errors++; $display("FAIL rdy_resume_addr: got %h required 00000402", trace[6]); end
        step();

        wlog_a.delete();
        wlog_d.delete();
        lsb_addr  = 32'h600;
        lsb_wdata = 32'hDEADBEEF;
        lsb_size  = 3'd2;
        lsb_wr    = 1'b1;
        lsb_valid = 1'b1;
        step();
        step();
        rst_in = 1'b1;
        step();
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL rst_mem_wr: got %b required 0", mem_wr); end
        checks++; if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin errors++; $display("FAIL rst_port: got a=%h d=%h required 0", mem_a, mem_dout); end
        checks++; if ({if_done, lsb_done, if_data, lsb_rdata} !== 66'h0) begin errors++; $display("FAIL rst_outputs: got %h required 0", {if_done, lsb_done, if_data, lsb_rdata}); end
        lsb_valid = 1'b0;
        rst_in    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (lsb_done || mem_wr) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_quiet: got %b required 0", bad); end
        checks++; if (wlog_a.size() !== 2) begin errors++; $display("FAIL rst_write_count: got %0d required 2", wlog_a.size()); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        mem_din        = 8'h00;
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        rob_clear_up   = 1'b0;
        io_buffer_full = 1'b0;
        if_valid       = 1'b0;
        if_addr        = '0;
        lsb_valid      = 1'b0;
        lsb_wr         = 1'b0;
        lsb_size       = '0;
        lsb_addr       = '0;
        lsb_wdata      = '0;

        test_reset();
        test_fetch();
        test_arbitration();
        test_halfword_store();
        test_io_stall();
        test_flush();
        test_rdy_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide external RAM port.
- Arbitrates between instruction fetch (fixed 4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Serialises each request into little-endian byte accesses and returns assembled data with a one-cycle done pulse.
- Aborts in-flight reads on ROB flush; stalls IO-mapped writes while the IO buffer is full.

Parameters:
IO_ADDR_MASK, 32'h0003_0000, address bits that mark IO space (a write is IO when (addr & mask) == mask)

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global ready; low freezes all state
rob_clear_up  in  1  pipeline flush from ROB
io_buffer_full  in  1  UART buffer full
mem_din  in  8  RAM read byte, valid one cycle after its address is presented
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM byte address
mem_wr  out  1  1 = write, 0 = read
if_valid  in  1  fetch request, held until if_done
if_addr  in  32  fetch address
if_done  out  1  one-cycle pulse, fetch data valid
if_data  out  32  fetched word
lsb_valid  in  1  LSB request, held until lsb_done
lsb_wr  in  1  1 = store, 0 = load
lsb_size  in  3  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (others treated as 4)
lsb_addr  in  32  access address
lsb_wdata  in  32  store data, low N bytes used
lsb_done  out  1  one-cycle pulse, load data valid / store retired
lsb_rdata  out  32  load data, zero-extended (LSB sign-extends)

Behaviour:
- All outputs registered. Reset and idle values: mem_a = 0, mem_dout = 0, mem_wr = 0, if_done = 0, lsb_done = 0, if_data = 0, lsb_rdata = 0, state = IDLE.
- rdy_in = 0: no register changes; flush, acceptance and byte capture are suppressed.
- States: IDLE, READ, WRITE. Internal: owner (IF or LSB), base address, N (byte count), issue counter, capture counter, byte accumulator.
- Acceptance (IDLE only, rob_clear_up = 0):
  - LSB has priority over IF when both valid.
  - A port is not accepted in the cycle its own done pulse is high.
  - A write whose address is IO space is not accepted while io_buffer_full = 1; if if_valid is high it proceeds instead.
- Read (N bytes, accept edge E0):
  - E0: mem_a <= addr, mem_wr <= 0.
  - E(k), k = 1..N-1: mem_a <= addr + k.
  - Edge E(k+2) captures mem_din as byte k into bits [8k+7:8k].
  - At E(N+1): final byte captured, data output and done registered, state <= IDLE, mem_a <= 0.
  - Latency: done is high in the cycle after E(N+1). A 4-byte read gives done 5 cycles after acceptance; a 1-byte read gives done 2 cycles after acceptance.
- Write (N bytes):
  - E0: mem_a <= addr, mem_dout <= byte0, mem_wr <= 1.
  - E(k): address addr + k with byte k.
  - At E(N): mem_wr <= 0, lsb_done <= 1, state <= IDLE.
  - Exactly N cycles with mem_wr = 1.
- Address arithmetic: addr + k is 32-bit wrap-around.
- Unused data bytes: upper bytes of lsb_rdata are 0 for N < 4.
- rob_clear_up = 1 (with rdy_in = 1):
  - Any READ (IF or LSB) aborts: state <= IDLE, mem_a <= 0, no done pulse, partial data discarded.
  - A WRITE in progress completes normally, including lsb_done.
  - No acceptance that cycle.
- rob_clear_up during rdy_in = 0 is ignored.
- Reset mid-operation: immediate return to reset values; no done pulse; write stops after the current edge.
- Done pulses last exactly one cycle. if_done and lsb_done are never high simultaneously.

Test Plan:
- Fetch read: if_addr = 0x100, RAM[0x100..0x103] = 13 05 00 00 -> mem_a sequence 0x100..0x103, if_done exactly 5 cycles after accept, if_data = 0x00000513, mem_wr = 0 throughout.
- Arbitration: if_valid and lsb_valid (load, size 0, addr 0x200, byte 0xF0) asserted the same cycle -> LSB served first, lsb_rdata = 0x000000F0; fetch is accepted the cycle after lsb_done and completes afterwards.
- Halfword store: addr 0x1FFF, wdata 0xAABBCCDD, size 1 -> mem_wr high 2 cycles, bytes 0xDD@0x1FFF and 0xCC@0x2000, then lsb_done.
- IO stall: store size 0 to 0x30000 with io_buffer_full = 1 for 10 cycles -> mem_wr stays 0; after it drops, the write occurs and lsb_done follows; a fetch pending meanwhile completes during the stall.
- Flush: rob_clear_up pulsed on the 3rd cycle of a fetch -> no if_done, mem_a = 0 next cycle; a new fetch to 0x400 then returns correct data. The same flush during a 4-byte store -> all 4 bytes written and lsb_done pulses.
- rdy_in low for 3 cycles mid-read, plus synchronous reset mid-write -> read resumes with correct data and latency extended by 3; reset forces mem_wr = 0 and all outputs to 0 on the next edge.
